// File: rtl/twiddle_cmul_if.sv
// Handshake and data bundle between the coefficient mapper / sample source
// and the twiddle complex multiplier.
interface twiddle_cmul_if #(
    parameter int MSB = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [MSB-1:0] x_re;
    logic signed [MSB-1:0] x_im;
    logic                  coef_en;
    logic signed [MSB-1:0] coef;
    logic [1:0]            coef_sel;
    logic signed [MSB-1:0] y_re;
    logic signed [MSB-1:0] y_im;
    logic                  out_valid;

    modport master (
        output in_valid, x_re, x_im, coef_en, coef, coef_sel,
        input  in_ready, y_re, y_im, out_valid
    );

    modport slave (
        input  in_valid, x_re, x_im, coef_en, coef, coef_sel,
        output in_ready, y_re, y_im, out_valid
    );
endinterface

// File: rtl/twiddle_cmul.sv
// Three-multiply complex multiplier (sample x twiddle) sharing one signed
// multiplier across serially delivered coefficient words C, C+S, S-C.
module twiddle_cmul #(
    parameter int MSB    = 16,
    parameter int COEF_W = 9,
    parameter int FRAC   = 7
) (
    input  logic           clk,
    input  logic           rst,
    twiddle_cmul_if.slave  bus
);
    localparam int SW = MSB + 1;
    localparam int PW = MSB + 1 + COEF_W;
    localparam int AW = MSB + COEF_W + 2;
    localparam logic signed [AW-1:0] Y_MAX = AW'(2 ** (MSB - 1) - 1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [2:0] {
        IDLE,
        STEP0,
        STEP1,
        STEP2,
        OUT
    } state_t;

    state_t                state_q, state_d;
    logic signed [MSB-1:0] a_q, a_d;
    logic signed [MSB-1:0] b_q, b_d;
    logic signed [PW-1:0]  k1_q, k1_d;
    logic signed [PW-1:0]  k3_q, k3_d;
    logic signed [MSB-1:0] y_re_q, y_re_d;
    logic signed [MSB-1:0] y_im_q, y_im_d;

    logic signed [SW-1:0]     mul_a;
    logic signed [COEF_W-1:0] mul_b;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     re_acc;
    logic signed [AW-1:0]     im_acc;
    logic                     coef_hi_unused;

    function automatic logic signed [MSB-1:0] sat_shift(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] sh;
        sh = v >>> FRAC;
        if (sh > Y_MAX) begin
            return Y_MAX[MSB-1:0];
        end else if (sh < Y_MIN) begin
            return Y_MIN[MSB-1:0];
        end
        return sh[MSB-1:0];
    endfunction

    assign coef_hi_unused = ^bus.coef[MSB-1:COEF_W];

    // The one shared multiplier: operand A is steered by state.
    always_comb begin
        mul_b = bus.coef[COEF_W-1:0];
        case (state_q)
            STEP0:   mul_a = SW'(a_q) + SW'(b_q);
            STEP1:   mul_a = SW'(b_q);
            default: mul_a = SW'(a_q);
        endcase
        prod = PW'(mul_a) * PW'(mul_b);
    end

    // k2 is consumed on the cycle it is produced, so the result registers
    // load at the STEP2 -> OUT edge and out_valid is simply the OUT state.
    always_comb begin
        re_acc = AW'(k1_q) - AW'(k3_q);
        im_acc = AW'(k1_q) + AW'(prod);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k1_d    = k1_q;
        k3_d    = k3_q;
        y_re_d  = y_re_q;
        y_im_d  = y_im_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.x_re;
                    b_d     = bus.x_im;
                    state_d = STEP0;
                end
            end
            STEP0: begin
                if (bus.coef_en && bus.coef_sel == 2'd0) begin
                    k1_d    = prod;
                    state_d = STEP1;
                end
            end
            STEP1: begin
                if (bus.coef_en && bus.coef_sel == 2'd1) begin
                    k3_d    = prod;
                    state_d = STEP2;
                end
            end
            STEP2: begin
                if (bus.coef_en && bus.coef_sel == 2'd2) begin
                    y_re_d  = sat_shift(re_acc);
                    y_im_d  = sat_shift(im_acc);
                    state_d = OUT;
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k1_q    <= '0;
            k3_q    <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k1_q    <= k1_d;
            k3_q    <= k3_d;
            y_re_q  <= y_re_d;
            y_im_q  <= y_im_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.y_re      = y_re_q;
    assign bus.y_im      = y_im_q;
endmodule

// File: tb/tb_twiddle_cmul.sv
// Directed bench for twiddle_cmul: a vector table of hand-computed products
// plus sequences for stalls, back-pressure and mid-operation reset.
module tb_twiddle_cmul;
    localparam int MSB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    twiddle_cmul_if #(.MSB(MSB)) bus ();

    twiddle_cmul #(.MSB(MSB), .COEF_W(9), .FRAC(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    a;
        int    b;
        int    c0;
        int    c1;
        int    c2;
        int    re;
        int    im;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_coef(input logic en, input int sel, input int val);
        bus.coef_en  = en;
        bus.coef_sel = 2'(sel);
        bus.coef     = MSB'(val);
    endtask

    task automatic run_vector(input string name, input int a, input int b,
                              input int c0, input int c1, input int c2,
                              input int re, input int im);
        check({name, ".in_ready_idle"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.x_re     = MSB'(a);
        bus.x_im     = MSB'(b);
        tick();
        bus.in_valid = 1'b0;
        check({name, ".in_ready_busy"}, 32'(bus.in_ready), 0);
        drive_coef(1'b1, 0, c0);
        tick();
        drive_coef(1'b1, 1, c1);
        tick();
        check({name, ".early_valid"}, 32'(bus.out_valid), 0);
        drive_coef(1'b1, 2, c2);
        tick();
        drive_coef(1'b0, 0, 0);
        check({name, ".out_valid"}, 32'(bus.out_valid), 1);
        check({name, ".y_re"}, bus.y_re, re);
        check({name, ".y_im"}, bus.y_im, im);
        tick();
        check({name, ".valid_drop"}, 32'(bus.out_valid), 0);
        check({name, ".ready_back"}, 32'(bus.in_ready), 1);
        check({name, ".y_re_hold"}, bus.y_re, re);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int a_s;
        int b_s;
        int cyc;

        tbl[0] = '{"identity",   100,    50,    127,  127, -127,    99,    49};
        tbl[1] = '{"minus_j",    100,    50,      0, -128, -128,    50,  -100};
        tbl[2] = '{"sat",     -32768, -32768,     0, -128, -128, -32768, 32767};
        tbl[3] = '{"plus_j",     100,    50,      0,  128,  128,   -50,   100};
        tbl[4] = '{"trunc_neg",   -3,     0,    127,  127, -127,    -3,     0};
        tbl[5] = '{"minus_one", 1000, -2000,   -128, -128,  128, -1000,  2000};
        tbl[6] = '{"sat_im",   32767, -32768,  -128, -128,  128, -32767, 32767};
        tbl[7] = '{"diag45",    1000,     0,     91,  182,    0,   710,   710};
        tbl[8] = '{"general",    300,  -200,    100,   50, -150,   156,  -274};

        bus.in_valid = 1'b0;
        bus.x_re     = '0;
        bus.x_im     = '0;
        drive_coef(1'b0, 0, 0);

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset.in_ready", 32'(bus.in_ready), 1);
        check("reset.out_valid", 32'(bus.out_valid), 0);
        check("reset.y_re", bus.y_re, 0);
        check("reset.y_im", bus.y_im, 0);

        // coefficient words in IDLE must not disturb anything
        drive_coef(1'b1, 0, 55);
        tick();
        drive_coef(1'b0, 0, 0);
        check("idle_coef.in_ready", 32'(bus.in_ready), 1);
        check("idle_coef.out_valid", 32'(bus.out_valid), 0);

        for (int i = 0; i < 9; i++) begin
            run_vector(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].c0, tbl[i].c1,
                       tbl[i].c2, tbl[i].re, tbl[i].im);
        end

        // stalls and wrong-select words inside every step state
        bus.in_valid = 1'b1;
        bus.x_re     = 16'sd100;
        bus.x_im     = 16'sd50;
        tick();
        bus.in_valid = 1'b0;
        drive_coef(1'b0, 0, 127);
        tick();
        check("gap.stall1", 32'(bus.out_valid), 0);
        tick();
        check("gap.stall2", 32'(bus.out_valid), 0);
        drive_coef(1'b1, 3, 33);
        tick();
        check("gap.sel3", 32'(bus.out_valid), 0);
        drive_coef(1'b1, 1, 77);
        tick();
        check("gap.sel1_early", 32'(bus.in_ready), 0);
        drive_coef(1'b1, 0, 127);
        tick();
        drive_coef(1'b1, 2, -5);
        tick();
        drive_coef(1'b1, 1, 127);
        tick();
        drive_coef(1'b1, 0, 40);
        tick();
        check("gap.sel0_in_step2", 32'(bus.out_valid), 0);
        drive_coef(1'b1, 2, -127);
        tick();
        check("gap.out_valid", 32'(bus.out_valid), 1);
        check("gap.y_re", bus.y_re, 99);
        check("gap.y_im", bus.y_im, 49);
        drive_coef(1'b1, 0, 9);
        tick();
        drive_coef(1'b0, 0, 0);
        check("gap.ready_after", 32'(bus.in_ready), 1);
        check("gap.single_pulse", 32'(bus.out_valid), 0);

        // in_valid held high with a sample that changes every cycle
        cyc = 0;
        bus.in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            a_s      = 200 + 10 * cyc;
            b_s      = -30 - cyc;
            bus.x_re = MSB'(a_s);
            bus.x_im = MSB'(b_s);
            check("bp.ready_idle", 32'(bus.in_ready), 1);
            tick();
            for (int st = 0; st < 3; st++) begin
                cyc++;
                bus.x_re = MSB'(200 + 10 * cyc);
                bus.x_im = MSB'(-30 - cyc);
                check("bp.ready_busy", 32'(bus.in_ready), 0);
                drive_coef(1'b1, st, (st == 2) ? -127 : 127);
                tick();
            end
            cyc++;
            bus.x_re = MSB'(200 + 10 * cyc);
            bus.x_im = MSB'(-30 - cyc);
            drive_coef(1'b0, 0, 0);
            check("bp.ready_out", 32'(bus.in_ready), 0);
            check("bp.out_valid", 32'(bus.out_valid), 1);
            check("bp.y_re", bus.y_re, (127 * a_s) >>> 7);
            check("bp.y_im", bus.y_im, (127 * b_s) >>> 7);
            tick();
            cyc++;
            check("bp.valid_drop", 32'(bus.out_valid), 0);
        end
        bus.in_valid = 1'b0;
        tick();
        tick();

        // reset while waiting in STEP2
        bus.in_valid = 1'b1;
        bus.x_re     = 16'sd100;
        bus.x_im     = 16'sd50;
        tick();
        bus.in_valid = 1'b0;
        drive_coef(1'b1, 0, 127);
        tick();
        drive_coef(1'b1, 1, 127);
        tick();
        drive_coef(1'b1, 2, -127);
        rst = 1'b1;
        #2;
        check("rst.in_ready", 32'(bus.in_ready), 1);
        check("rst.out_valid", 32'(bus.out_valid), 0);
        check("rst.y_re", bus.y_re, 0);
        check("rst.y_im", bus.y_im, 0);
        tick();
        rst = 1'b0;
        tick();
        drive_coef(1'b0, 0, 0);
        check("rst.no_valid", 32'(bus.out_valid), 0);
        tick();
        check("rst.no_valid2", 32'(bus.out_valid), 0);
        run_vector("after_rst", 100, 50, 127, 127, -127, 99, 49);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
